// File: rtl/o_serdes_tx_ctrl.sv
// O_SERDES transmit-lane sequencer: PLL lock -> warmup -> training -> user stream; 1-cycle decision latency, user data accepted once per word slot.
// Optional channel bonding (BOND_WAIT state, bond sync ports) is enabled with `define O_SERDES_TX_CTRL_BOND_EN.
module o_serdes_tx_ctrl #(
    parameter int               WIDTH         = 4,
    parameter int               WORD_PERIOD   = 4,
    parameter int               LOCK_WAIT     = 16,
    parameter int               TRAIN_WORDS   = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(4'b1010),
    parameter logic [WIDTH-1:0] IDLE_PATTERN  = '0
) (
    input  logic             i_clk_in,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_pll_lock,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_data_valid,
    output logic             o_data_ready,
    output logic [WIDTH-1:0] o_d_out,
    output logic             o_load_word,
    output logic             o_oe,
    output logic             o_clk_en,
    output logic             o_link_up,
`ifdef O_SERDES_TX_CTRL_BOND_EN
    input  logic             i_channel_bond_sync_in,
    output logic             o_channel_bond_sync_out,
`endif
    output logic [7:0]       o_underrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_TRAIN,
`ifdef O_SERDES_TX_CTRL_BOND_EN
        S_BOND_WAIT,
`endif
        S_RUN
    } state_t;

    localparam logic [3:0] PH_LAST = 4'(WORD_PERIOD - 1);
    localparam logic [7:0] LW_LAST = 8'(LOCK_WAIT - 1);
    localparam logic [7:0] TW_LAST = 8'(TRAIN_WORDS - 1);

    state_t           r_state;
    logic [3:0]       r_phase;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       r_word_cnt;
    logic [7:0]       r_underrun;
    logic [WIDTH-1:0] r_d_out;
    logic             r_load_word;
    logic             r_oe;
    logic             r_clk_en;
    logic             r_link_up;
    logic             r_lock_meta;
    logic             r_lock_s;

    logic w_abort;
    logic w_slot;
    logic w_xfer;

    always_ff @(posedge i_clk_in or negedge i_rst) begin
        if (!i_rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= i_pll_lock;
            r_lock_s    <= r_lock_meta;
        end
    end

`ifdef O_SERDES_TX_CTRL_BOND_EN
    logic r_bond_meta;
    logic r_bond_s;
    logic r_bond_out;

    always_ff @(posedge i_clk_in or negedge i_rst) begin
        if (!i_rst) begin
            r_bond_meta <= 1'b0;
            r_bond_s    <= 1'b0;
        end else begin
            r_bond_meta <= i_channel_bond_sync_in;
            r_bond_s    <= r_bond_meta;
        end
    end

    assign o_channel_bond_sync_out = r_bond_out;
`endif

    assign w_abort = !(i_enable && r_lock_s);
    assign w_slot  = (r_phase == PH_LAST);
    // Abort wins over a transfer: ready drops the same cycle the abort is seen.
    assign o_data_ready = (r_state == S_RUN) && w_slot && !w_abort;
    assign w_xfer       = o_data_ready && i_data_valid;

    always_ff @(posedge i_clk_in or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_phase     <= 4'd0;
            r_wait_cnt  <= 8'd0;
            r_word_cnt  <= 8'd0;
            r_underrun  <= 8'd0;
            r_d_out     <= '0;
            r_load_word <= 1'b0;
            r_oe        <= 1'b0;
            r_clk_en    <= 1'b0;
            r_link_up   <= 1'b0;
`ifdef O_SERDES_TX_CTRL_BOND_EN
            r_bond_out  <= 1'b0;
`endif
        end else begin
            r_load_word <= 1'b0;
`ifdef O_SERDES_TX_CTRL_BOND_EN
            r_bond_out  <= 1'b0;
`endif
            if (r_state != S_IDLE && w_abort) begin
                r_state    <= S_IDLE;
                r_phase    <= 4'd0;
                r_wait_cnt <= 8'd0;
                r_word_cnt <= 8'd0;
                r_d_out    <= '0;
                r_oe       <= 1'b0;
                r_clk_en   <= 1'b0;
                r_link_up  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_abort) begin
                            r_state    <= S_WARMUP;
                            r_clk_en   <= 1'b1;
                            r_wait_cnt <= 8'd0;
                        end
                    end
                    S_WARMUP: begin
                        if (r_wait_cnt == LW_LAST) begin
                            r_state    <= S_TRAIN;
                            r_oe       <= 1'b1;
                            r_word_cnt <= 8'd0;
                            r_phase    <= 4'd0;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 8'd1;
                        end
                    end
                    S_TRAIN: begin
                        r_phase <= w_slot ? 4'd0 : r_phase + 4'd1;
                        if (w_slot) begin
                            r_d_out     <= TRAIN_PATTERN;
                            r_load_word <= 1'b1;
                            if (r_word_cnt == TW_LAST) begin
`ifdef O_SERDES_TX_CTRL_BOND_EN
                                r_state    <= S_BOND_WAIT;
                                r_bond_out <= 1'b1;
`else
                                r_state    <= S_RUN;
                                r_link_up  <= 1'b1;
`endif
                            end else begin
                                r_word_cnt <= r_word_cnt + 8'd1;
                            end
                        end
                    end
`ifdef O_SERDES_TX_CTRL_BOND_EN
                    S_BOND_WAIT: begin
                        r_phase <= w_slot ? 4'd0 : r_phase + 4'd1;
                        if (w_slot) begin
                            r_d_out     <= TRAIN_PATTERN;
                            r_load_word <= 1'b1;
                            if (r_bond_s) begin
                                r_state   <= S_RUN;
                                r_link_up <= 1'b1;
                            end
                        end
                    end
`endif
                    S_RUN: begin
                        r_phase <= w_slot ? 4'd0 : r_phase + 4'd1;
                        if (w_slot) begin
                            r_load_word <= 1'b1;
                            if (w_xfer) begin
                                r_d_out <= i_data_in;
                            end else begin
                                r_d_out <= IDLE_PATTERN;
                                if (r_underrun != 8'hFF) begin
                                    r_underrun <= r_underrun + 8'd1;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_d_out        = r_d_out;
    assign o_load_word    = r_load_word;
    assign o_oe           = r_oe;
    assign o_clk_en       = r_clk_en;
    assign o_link_up      = r_link_up;
    assign o_underrun_cnt = r_underrun;

endmodule
